mmio_irq_timer: RTL and testbench
=================================

// Module: mmio_irq_timer
// PURPOSE
//  Memory-mapped responder on the MIPS core data bus (memwrite/dataadr/writedata).
//  Gives the core a programmable timer and software-triggered interrupt pulses,
//  and drives the core's 8-bit interrupts input.
//  Synthesizable on-chip source of the stimulus that benches drive by hand.
// PARAMETERS
//  BASE_ADDR   32'h1FFF_0000  word-aligned base; block decodes dataadr[31:5]==BASE_ADDR[31:5]
//  TIMER_IRQ   1              interrupts[] bit raised by timer match (0..7)
//  PULSE_CYC   5              width, in ph1 cycles, of a software interrupt pulse (>=1)
//  PRESCALE    1              ph1 cycles per COUNT increment (>=1)
// PORTS
//  ph1         in   1   single system clock, all state on rising edge
//  reset_b     in   1   asynchronous, active-low reset
//  memwrite    in   1   core store strobe
//  dataadr     in   32  core data address
//  writedata   in   32  core store data
//  readdata    out  32  load data, combinational; 0 when not selected
//  sel         out  1   dataadr hits this block (combinational)
//  interrupts  out  8   to core interrupt inputs, registered
// BEHAVIOUR
//  Register map (offset = dataadr[4:2]*4), writes take effect on the next ph1 edge:
//   0x00 COUNT   RW 32  free counter; a write loads it and clears the prescaler
//   0x04 COMPARE RW 32  match value
//   0x08 CTRL    RW 3   [0] en, [1] autoreload, [2] irq_en
//   0x0C STATUS  R/W1C 8  pending bits; write 1 to clear
//   0x10 SWIRQ   W  8   each written 1 starts a PULSE_CYC pulse on that line; reads 0
//   0x14-0x1C    reserved: reads 0, writes ignored
//  Reset (reset_b=0, async): COUNT=0, COMPARE=32'hFFFF_FFFF, CTRL=0, STATUS=0,
//   prescaler=0, pulse counters=0, interrupts=8'h00.
//  Timer: when en, prescaler counts 0..PRESCALE-1; on terminal value COUNT+=1
//   (wraps 32'hFFFF_FFFF->0, no side effect). Match = en & tick & (COUNT==COMPARE).
//   On match: STATUS[TIMER_IRQ]<=1; autoreload ? COUNT<=0 : CTRL.en<=0.
//  interrupts[i] <= (STATUS[i] & CTRL.irq_en) | pulse_active[i]  (1 cycle latency).
//  SWIRQ pulse: line goes high the cycle after the write, stays high exactly PULSE_CYC
//   cycles; a new write to an active line restarts its counter (no gap, no glitch).
//  Simultaneous events, in priority order:
//   - match and W1C of same STATUS bit: set wins (pending stays 1)
//   - match and COUNT write: written value wins; STATUS still set
//   - match and CTRL write: CTRL takes written value; autoreload/clear-en not applied
//   - writes to non-selected addresses: no state change
//  Reset asserted mid-pulse or mid-count: all state returns to reset values immediately;
//   interrupts drop asynchronously.
//  memwrite with sel but reserved offset: ignored. Byte lanes not supported (full word only).
// STRUCTURE
//  mmio_defs.vh (shared include): register offsets, CTRL bit indices, reset constants;
//   also included by test programs' assembler headers.
//  One sub-module: irq_pulse_gen (per-line down-counter, PULSE_CYC width, restart on trigger),
//   instantiated x8 via generate. Decode, registers and timer stay in the top module.
// TESTING
//  1 Reset: hold reset_b=0 3 cycles -> interrupts=0, read COMPARE=FFFF_FFFF, STATUS=0.
//  2 Timer one-shot: COMPARE=10, CTRL=5 (en,irq_en) -> interrupts[1] high 12 cycles
//    after CTRL write, CTRL reads 4, COUNT holds 10; W1C STATUS=2 -> line low next cycle.
//  3 Autoreload, PRESCALE=4: COMPARE=3, CTRL=7 -> STATUS[1] set every 16 cycles, COUNT back to 0.
//  4 SWIRQ=8'h03 -> interrupts[1:0] high exactly 5 cycles; rewrite 8'h01 on cycle 3
//    -> bit0 stays high 5 more cycles, bit1 drops on schedule.
//  5 Collision: W1C STATUS[1] in match cycle -> STATUS[1]=1; COUNT write 100 in match
//    cycle -> COUNT=100 after.
//  6 Decode: store to BASE_ADDR+0x20 and +0x18 -> no register change, sel only for +0x18,
//    readdata=0 for both; async reset pulse mid-SWIRQ -> interrupts=0 at once.

Source files
------------

// File: rtl/mmio_irq_timer_pkg.sv
// Shared definitions for the MMIO timer / interrupt block: register map,
// CTRL layout and reset constants.
package mmio_irq_timer_pkg;

  // Word offset within the block, taken from dataadr[4:2].
  typedef enum logic [2:0] {
    RegCount   = 3'd0,
    RegCompare = 3'd1,
    RegCtrl    = 3'd2,
    RegStatus  = 3'd3,
    RegSwirq   = 3'd4,
    RegRsvd5   = 3'd5,
    RegRsvd6   = 3'd6,
    RegRsvd7   = 3'd7
  } reg_e;

  // CTRL register: bit 0 en, bit 1 autoreload, bit 2 irq_en.
  typedef struct packed {
    logic irq_en;
    logic autoreload;
    logic en;
  } ctrl_t;

  localparam logic [31:0] CountRst   = 32'h0000_0000;
  localparam logic [31:0] CompareRst = 32'hFFFF_FFFF;
  localparam ctrl_t       CtrlRst    = '{irq_en: 1'b0, autoreload: 1'b0, en: 1'b0};
  localparam logic [7:0]  StatusRst  = 8'h00;

endpackage

// File: rtl/mmio_irq_timer_pulse_gen.sv
// One software interrupt line: a trigger starts (or restarts) a pulse that is
// visible for exactly PULSE_CYC cycles once registered by the parent.
module mmio_irq_timer_pulse_gen #(
  parameter int unsigned PULSE_CYC = 5
) (
  input  logic ph1,
  input  logic reset_b,
  input  logic trig_i,
  output logic active_o
);

  localparam int unsigned    CntW   = $clog2(PULSE_CYC + 1);
  // The trigger cycle itself counts as the first pulse cycle.
  localparam logic [CntW-1:0] Reload = CntW'(PULSE_CYC - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Reload on trigger, otherwise count down to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (trig_i) begin
      cnt_d = Reload;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Remaining-cycles counter.
  always_ff @(posedge ph1 or negedge reset_b) begin
    if (!reset_b) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Next-cycle activity: trigger, or cycles still owed from an earlier trigger.
  assign active_o = trig_i | (cnt_q != '0);

endmodule

// File: rtl/mmio_irq_timer.sv
// Memory-mapped timer and software interrupt source on the core data bus.
// Decode, registers and timer live here; per-line pulse counters are sub-modules.
module mmio_irq_timer
  import mmio_irq_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1FFF_0000,
  parameter int unsigned TIMER_IRQ = 1,
  parameter int unsigned PULSE_CYC = 5,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        ph1,
  input  logic        reset_b,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        sel,
  output logic [7:0]  interrupts
);

  localparam logic [31:0] PreTerm  = 32'(PRESCALE - 1);
  localparam logic [7:0]  TimerBit = 8'(1) << TIMER_IRQ;

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic [7:0]  status_q, status_d;
  logic [31:0] presc_q, presc_d;
  logic [7:0]  irq_q, irq_d;

  reg_e       reg_sel;
  logic       wr_en;
  logic       tick;
  logic       match;
  logic [7:0] status_set;
  logic [7:0] swirq_trig;
  logic [7:0] pulse_active;
  logic       unused_addr_lsbs;

  assign unused_addr_lsbs = ^dataadr[1:0];

  // Address decode: block selected on the upper 27 address bits.
  always_comb begin
    sel     = (dataadr[31:5] == BASE_ADDR[31:5]);
    reg_sel = reg_e'(dataadr[4:2]);
    wr_en   = memwrite & sel;
  end

  // Combinational load data; zero when not selected or for write-only/reserved words.
  always_comb begin
    readdata = 32'h0;
    if (sel) begin
      case (reg_sel)
        RegCount:   readdata = count_q;
        RegCompare: readdata = compare_q;
        RegCtrl:    readdata = {29'h0, ctrl_q};
        RegStatus:  readdata = {24'h0, status_q};
        default:    readdata = 32'h0;
      endcase
    end
  end

  // Timer advance and match; bus writes are applied last so they win.
  always_comb begin
    tick       = ctrl_q.en & (presc_q == PreTerm);
    match      = tick & (count_q == compare_q);
    status_set = match ? TimerBit : 8'h00;

    presc_d    = presc_q;
    count_d    = count_q;
    compare_d  = compare_q;
    ctrl_d     = ctrl_q;
    status_d   = status_q | status_set;
    swirq_trig = 8'h00;

    if (ctrl_q.en) begin
      presc_d = tick ? 32'h0 : presc_q + 32'h1;
    end

    if (match) begin
      if (ctrl_q.autoreload) begin
        count_d = 32'h0;
      end else begin
        ctrl_d.en = 1'b0;
      end
    end else if (tick) begin
      count_d = count_q + 32'h1;
    end

    if (wr_en) begin
      case (reg_sel)
        RegCount: begin
          count_d = writedata;
          presc_d = 32'h0;
        end
        RegCompare: compare_d = writedata;
        RegCtrl:    ctrl_d = ctrl_t'(writedata[2:0]);
        // Clear first, then re-apply a coincident match so the set wins.
        RegStatus:  status_d = (status_q & ~writedata[7:0]) | status_set;
        RegSwirq:   swirq_trig = writedata[7:0];
        default:    ;
      endcase
    end
  end

  // Interrupt output: enabled pending bits plus software pulses.
  always_comb begin
    irq_d = (status_q & {8{ctrl_q.irq_en}}) | pulse_active;
  end

  // Register state with asynchronous reset.
  always_ff @(posedge ph1 or negedge reset_b) begin
    if (!reset_b) begin
      count_q   <= CountRst;
      compare_q <= CompareRst;
      ctrl_q    <= CtrlRst;
      status_q  <= StatusRst;
      presc_q   <= 32'h0;
      irq_q     <= 8'h00;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      ctrl_q    <= ctrl_d;
      status_q  <= status_d;
      presc_q   <= presc_d;
      irq_q     <= irq_d;
    end
  end

  assign interrupts = irq_q;

  for (genvar i = 0; i < 8; i++) begin : g_pulse
    mmio_irq_timer_pulse_gen #(
      .PULSE_CYC(PULSE_CYC)
    ) u_pulse (
      .ph1     (ph1),
      .reset_b (reset_b),
      .trig_i  (swirq_trig[i]),
      .active_o(pulse_active[i])
    );
  end

endmodule

// File: tb/tb_mmio_irq_timer.sv
// Scoreboard bench for mmio_irq_timer: stimulus queues expected values,
// a monitor compares them against the DUT outputs when presented.
module tb_mmio_irq_timer;

  localparam logic [31:0] Base = 32'h1FFF_0000;
  localparam int KRd   = 0;
  localparam int KIrq  = 1;
  localparam int KSel  = 2;
  localparam int KRd4  = 3;
  localparam int KIrq4 = 4;

  logic        ph1 = 1'b0;
  logic        reset_b;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic [31:0] readdata, readdata4;
  logic        sel, sel4;
  logic [7:0]  interrupts, interrupts4;

  // Default instance (PRESCALE=1) and a PRESCALE=4 instance on the same bus.
  mmio_irq_timer u_dut (
    .ph1       (ph1),
    .reset_b   (reset_b),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .readdata  (readdata),
    .sel       (sel),
    .interrupts(interrupts)
  );

  mmio_irq_timer #(
    .PRESCALE(4)
  ) u_dut4 (
    .ph1       (ph1),
    .reset_b   (reset_b),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .readdata  (readdata4),
    .sel       (sel4),
    .interrupts(interrupts4)
  );

  always #50 ph1 = ~ph1;

  string       name_q[$];
  int          kind_q[$];
  logic [31:0] exp_q[$];
  int          n_total = 0;
  int          n_pass  = 0;
  event        chk_ev;

  // Monitor: pop one expectation per presented output and compare.
  always @(chk_ev) begin
    string       nm;
    int          kd;
    logic [31:0] ex;
    logic [31:0] act;
    n_total++;
    if (exp_q.size() == 0) begin
      $display("FAIL scoreboard_underflow: got no expectation, want one queued");
    end else begin
      nm = name_q.pop_front();
      kd = kind_q.pop_front();
      ex = exp_q.pop_front();
      case (kd)
        KRd:     act = readdata;
        KIrq:    act = {24'h0, interrupts};
        KSel:    act = {31'h0, sel};
        KRd4:    act = readdata4;
        default: act = {24'h0, interrupts4};
      endcase
      if (act === ex) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, ex);
    end
  end

  task automatic tick();
    @(posedge ph1);
    #1;
  endtask

  task automatic wr_addr(input logic [31:0] addr, input logic [31:0] data);
    dataadr   = addr;
    writedata = data;
    memwrite  = 1'b1;
    tick();
    memwrite  = 1'b0;
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] data);
    wr_addr(Base + {27'h0, off}, data);
  endtask

  // Present an address, queue the expected output, and hand it to the monitor.
  task automatic chk(input string nm, input int kd, input logic [31:0] addr,
                     input logic [31:0] ex);
    memwrite = 1'b0;
    dataadr  = addr;
    name_q.push_back(nm);
    kind_q.push_back(kd);
    exp_q.push_back(ex);
    #1;
    ->chk_ev;
    #1;
  endtask

  initial begin
    reset_b   = 1'b1;
    memwrite  = 1'b0;
    dataadr   = 32'h0;
    writedata = 32'h0;
    #5 reset_b = 1'b0;

    // Reset values held for three cycles.
    repeat (3) tick();
    chk("rst_irq", KIrq, Base, 32'h00);
    chk("rst_irq4", KIrq4, Base, 32'h00);
    chk("rst_compare", KRd, Base + 32'h04, 32'hFFFF_FFFF);
    chk("rst_status", KRd, Base + 32'h0C, 32'h0);
    chk("rst_count", KRd, Base + 32'h00, 32'h0);
    chk("rst_ctrl", KRd, Base + 32'h08, 32'h0);
    reset_b = 1'b1;
    tick();

    // One-shot: match at count 10, line rises 12 edges after the CTRL write.
    wr(5'h04, 32'd10);
    wr(5'h08, 32'd5);
    repeat (11) tick();
    chk("os_irq_e11", KIrq, Base, 32'h00);
    chk("os_status_e11", KRd, Base + 32'h0C, 32'h2);
    tick();
    chk("os_irq_e12", KIrq, Base, 32'h02);
    chk("os_ctrl", KRd, Base + 32'h08, 32'h4);
    chk("os_count", KRd, Base + 32'h00, 32'd10);
    tick();
    chk("os_count_hold", KRd, Base + 32'h00, 32'd10);
    wr(5'h0C, 32'h2);
    chk("os_status_w1c", KRd, Base + 32'h0C, 32'h0);
    chk("os_irq_w1c_edge", KIrq, Base, 32'h02);
    tick();
    chk("os_irq_cleared", KIrq, Base, 32'h00);

    // Autoreload on the PRESCALE=4 instance: match every 16 cycles.
    wr(5'h08, 32'h0);
    wr(5'h0C, 32'hFF);
    wr(5'h00, 32'h0);
    wr(5'h04, 32'd3);
    wr(5'h08, 32'd7);
    repeat (15) tick();
    chk("ar_status_e15", KRd4, Base + 32'h0C, 32'h0);
    chk("ar_count_e15", KRd4, Base + 32'h00, 32'd3);
    tick();
    chk("ar_status_e16", KRd4, Base + 32'h0C, 32'h2);
    chk("ar_count_e16", KRd4, Base + 32'h00, 32'd0);
    chk("ar_irq_e16", KIrq4, Base, 32'h00);
    tick();
    chk("ar_irq_e17", KIrq4, Base, 32'h02);
    wr(5'h0C, 32'h2);
    chk("ar_status_clr", KRd4, Base + 32'h0C, 32'h0);
    repeat (13) tick();
    chk("ar_status_e31", KRd4, Base + 32'h0C, 32'h0);
    chk("ar_count_e31", KRd4, Base + 32'h00, 32'd3);
    tick();
    chk("ar_status_e32", KRd4, Base + 32'h0C, 32'h2);
    chk("ar_count_e32", KRd4, Base + 32'h00, 32'd0);

    // Software pulses: 5 cycles each, bit0 restarted two edges in.
    wr(5'h08, 32'h0);
    wr(5'h0C, 32'hFF);
    tick();
    chk("sw_idle", KIrq, Base, 32'h00);
    wr(5'h10, 32'h03);
    chk("sw_e0", KIrq, Base, 32'h03);
    chk("sw_reads0", KRd, Base + 32'h10, 32'h0);
    tick();
    chk("sw_e1", KIrq, Base, 32'h03);
    wr(5'h10, 32'h01);
    chk("sw_e2", KIrq, Base, 32'h03);
    tick();
    chk("sw_e3", KIrq, Base, 32'h03);
    tick();
    chk("sw_e4", KIrq, Base, 32'h03);
    tick();
    chk("sw_e5", KIrq, Base, 32'h01);
    tick();
    chk("sw_e6", KIrq, Base, 32'h01);
    tick();
    chk("sw_e7", KIrq, Base, 32'h00);

    // Collisions with a match (COMPARE=3, en+autoreload, match 4 edges in).
    wr(5'h08, 32'h0);
    wr(5'h0C, 32'hFF);
    wr(5'h00, 32'h0);
    wr(5'h04, 32'd3);
    wr(5'h08, 32'd3);
    repeat (3) tick();
    wr(5'h0C, 32'h2);
    chk("col_w1c_set_wins", KRd, Base + 32'h0C, 32'h2);
    chk("col_w1c_reload", KRd, Base + 32'h00, 32'd0);
    wr(5'h0C, 32'h2);
    chk("col_status_clr", KRd, Base + 32'h0C, 32'h0);
    repeat (2) tick();
    wr(5'h00, 32'd100);
    chk("col_count_wins", KRd, Base + 32'h00, 32'd100);
    chk("col_count_status", KRd, Base + 32'h0C, 32'h2);
    tick();
    chk("col_count_runs", KRd, Base + 32'h00, 32'd101);

    // Decode: off-block and reserved stores are ignored.
    wr(5'h08, 32'h0);
    wr(5'h0C, 32'hFF);
    wr(5'h00, 32'd7);
    wr_addr(Base + 32'h20, 32'h1234);
    wr_addr(Base + 32'h24, 32'h55);
    wr_addr(Base + 32'h18, 32'h1234);
    chk("dec_count", KRd, Base + 32'h00, 32'd7);
    chk("dec_compare", KRd, Base + 32'h04, 32'd3);
    chk("dec_ctrl", KRd, Base + 32'h08, 32'h0);
    chk("dec_status", KRd, Base + 32'h0C, 32'h0);
    chk("dec_sel_20", KSel, Base + 32'h20, 32'h0);
    chk("dec_rd_20", KRd, Base + 32'h20, 32'h0);
    chk("dec_sel_18", KSel, Base + 32'h18, 32'h1);
    chk("dec_rd_18", KRd, Base + 32'h18, 32'h0);
    chk("dec_sel_00", KSel, Base, 32'h1);

    // Asynchronous reset in the middle of a pulse.
    wr(5'h10, 32'h80);
    chk("ar_pulse_on", KIrq, Base, 32'h80);
    reset_b = 1'b0;
    chk("async_irq", KIrq, Base, 32'h00);
    chk("async_irq4", KIrq4, Base, 32'h00);
    chk("async_count", KRd, Base + 32'h00, 32'h0);
    chk("async_compare", KRd, Base + 32'h04, 32'hFFFF_FFFF);
    tick();
    reset_b = 1'b1;
    tick();
    chk("post_rst_irq", KIrq, Base, 32'h00);

    #10;
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_leftover: got %0d pending, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
